sm2c_share_ctrl: RTL and testbench

//   Sequencer/arbiter sharing one sign-magnitude to 2's-complement converter between two requesters.
//   - Round-robin arbitration selects one requester.
//   - The selected operand is registered and converted in one clock.
//   - The result is held on a valid/ready output until the consumer accepts it.
//   - Sits between SM-format producers (e.g. keypad/ADC front ends) and 2's-complement arithmetic units.

---
 rtl/sm2c_share_ctrl.sv | 143 ++++++++++++++
 tb/tb_sm2c_share_ctrl.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/sm2c_share_ctrl.sv
// rtl/sm2c_share_ctrl.sv - shared sign-magnitude to 2's-complement converter with round-robin arbitration
//
// Purpose:
//   Two requesters share a single sign-magnitude to 2's-complement converter.
//   A round-robin arbiter grants one requester in IDLE, its operand is latched,
//   converted in CONV, and the result is presented in HOLD on a valid/ready
//   interface until the consumer takes it.
//
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   req0/sm0   requester 0 request and sign-magnitude operand
//   req1/sm1   requester 1 request and sign-magnitude operand
//   ack0/ack1  one-cycle capture acknowledge per requester
//   out_valid  result valid
//   out_ready  consumer accepts the result
//   y          2's-complement result
//   out_id     requester index of the current result
//   negz       operand was negative zero

module sm2c_share_ctrl #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         req0,
   input  logic [W-1:0] sm0,
   input  logic         req1,
   input  logic [W-1:0] sm1,
   output logic         ack0,
   output logic         ack1,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] y,
   output logic         out_id,
   output logic         negz
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CONV = 2'd1,
      HOLD = 2'd2
   } state_t;

   state_t         state, state_nx;
   logic           rr_ptr, rr_ptr_nx;
   logic [W-1:0]   op, op_nx;
   logic           op_id, op_id_nx;
   logic           ack0_nx, ack1_nx;
   logic           out_valid_nx;
   logic [W-1:0]   y_nx;
   logic           out_id_nx;
   logic           negz_nx;

   logic           grant;
   logic [W-2:0]   mag;
   logic [W-1:0]   conv_y;
   logic           conv_negz;

   // Round-robin only matters under contention; a lone requester always wins.
   assign grant = (req0 & req1) ? rr_ptr : req1;

   assign mag = op[W-2:0];

   // Negative zero naturally maps to 0 under the negate-mod-2^W rule, so the
   // only special handling it needs is the negz flag.
   always_comb begin
      conv_y = {1'b0, mag};
      if (op[W-1]) begin
         conv_y = ~{1'b0, mag} + {{(W-1){1'b0}}, 1'b1};
      end
      conv_negz = op[W-1] & (mag == '0);
   end

   always_comb begin
      state_nx     = state;
      rr_ptr_nx    = rr_ptr;
      op_nx        = op;
      op_id_nx     = op_id;
      ack0_nx      = 1'b0;
      ack1_nx      = 1'b0;
      out_valid_nx = out_valid;
      y_nx         = y;
      out_id_nx    = out_id;
      negz_nx      = negz;
      case (state)
         IDLE: begin
            if (req0 | req1) begin
               op_nx    = grant ? sm1 : sm0;
               op_id_nx = grant;
               ack0_nx  = ~grant;
               ack1_nx  = grant;
               state_nx = CONV;
            end
         end
         CONV: begin
            y_nx         = conv_y;
            out_id_nx    = op_id;
            negz_nx      = conv_negz;
            out_valid_nx = 1'b1;
            state_nx     = HOLD;
         end
         HOLD: begin
            if (out_ready) begin
               out_valid_nx = 1'b0;
               // The requester just served yields priority to the other one.
               rr_ptr_nx    = ~out_id;
               state_nx     = IDLE;
            end
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         rr_ptr    <= 1'b0;
         op        <= '0;
         op_id     <= 1'b0;
         ack0      <= 1'b0;
         ack1      <= 1'b0;
         out_valid <= 1'b0;
         y         <= '0;
         out_id    <= 1'b0;
         negz      <= 1'b0;
      end else begin
         state     <= state_nx;
         rr_ptr    <= rr_ptr_nx;
         op        <= op_nx;
         op_id     <= op_id_nx;
         ack0      <= ack0_nx;
         ack1      <= ack1_nx;
         out_valid <= out_valid_nx;
         y         <= y_nx;
         out_id    <= out_id_nx;
         negz      <= negz_nx;
      end
   end

endmodule

// File: tb/tb_sm2c_share_ctrl.sv
// tb/tb_sm2c_share_ctrl.sv - self-checking bench for sm2c_share_ctrl

module tb_sm2c_share_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       req0, req1;
   logic [3:0] sm0, sm1;
   logic       ack0, ack1;
   logic       out_valid;
   logic       out_ready;
   logic [3:0] y;
   logic       out_id;
   logic       negz;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   sm2c_share_ctrl #(.W(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req0      (req0),
      .sm0       (sm0),
      .req1      (req1),
      .sm1       (sm1),
      .ack0      (ack0),
      .ack1      (ack1),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .y         (y),
      .out_id    (out_id),
      .negz      (negz)
   );

   typedef struct {
      logic       r0;
      logic [3:0] s0;
      logic       r1;
      logic [3:0] s1;
      logic       id;
      logic [3:0] ey;
      logic       enegz;
   } vec_t;

   vec_t tbl[6];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Reference conversion via signed integer arithmetic.
   task automatic model(input logic [3:0] s, output logic [3:0] ey, output logic en);
      int m;
      int v;
      m  = int'(s[2:0]);
      v  = s[3] ? -m : m;
      ey = v[3:0];
      en = s[3] && (m == 0);
   endtask

   // Waits on negedges until an ack is seen or the bound expires.
   task automatic wait_ack(input string nm, output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(ack0 | ack1) && n < 10);
      if (!(ack0 | ack1)) check({nm, "_ack_timeout"}, 0, 1);
   endtask

   // Full single transaction from IDLE with out_ready held high.
   task automatic run_txn(input string nm, input logic r0, input logic [3:0] s0,
                          input logic r1, input logic [3:0] s1,
                          input logic eid, input logic [3:0] ey, input logic en);
      int n;
      req0 = r0; sm0 = s0; req1 = r1; sm1 = s1; out_ready = 1'b1;
      wait_ack(nm, n);
      check({nm, "_latency"}, n, 1);
      check({nm, "_ack0"}, ack0, !eid);
      check({nm, "_ack1"}, ack1, eid);
      req0 = 1'b0; req1 = 1'b0;
      @(negedge clk);
      check({nm, "_valid"}, out_valid, 1);
      check({nm, "_y"}, y, ey);
      check({nm, "_id"}, out_id, eid);
      check({nm, "_negz"}, negz, en);
      check({nm, "_ack_gone"}, {ack0, ack1}, 0);
      @(negedge clk);
      check({nm, "_valid_drop"}, out_valid, 0);
   endtask

   initial begin
      int n;
      logic [3:0] ey;
      logic       en;
      logic       exp_g[3];

      tbl[0] = '{1'b1, 4'b1101, 1'b0, 4'b0000, 1'b0, 4'b1011, 1'b0};
      tbl[1] = '{1'b1, 4'b1000, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b1};
      tbl[2] = '{1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0};
      tbl[3] = '{1'b0, 4'b0000, 1'b1, 4'b1111, 1'b1, 4'b1001, 1'b0};
      tbl[4] = '{1'b1, 4'b0111, 1'b0, 4'b0000, 1'b0, 4'b0111, 1'b0};
      tbl[5] = '{1'b0, 4'b0000, 1'b1, 4'b0110, 1'b1, 4'b0110, 1'b0};
      exp_g[0] = 1'b0; exp_g[1] = 1'b1; exp_g[2] = 1'b0;

      rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0; sm0 = '0; sm1 = '0; out_ready = 1'b1;
      repeat (2) @(negedge clk);
      check("rst_valid", out_valid, 0);
      check("rst_y", y, 0);
      check("rst_ack", {ack0, ack1}, 0);
      check("rst_id", out_id, 0);
      check("rst_negz", negz, 0);
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_release_ack", {ack0, ack1}, 0);

      // Contention from reset: both requests held, expect grants 0,1,0.
      req0 = 1'b1; sm0 = 4'b0011; req1 = 1'b1; sm1 = 4'b1010;
      for (int k = 0; k < 3; k++) begin
         wait_ack($sformatf("cont%0d", k), n);
         check($sformatf("cont%0d_overlap", k), ack0 & ack1, 0);
         check($sformatf("cont%0d_grant", k), ack1, exp_g[k]);
         @(negedge clk);
         if (k == 2) begin req0 = 1'b0; req1 = 1'b0; end
         check($sformatf("cont%0d_valid", k), out_valid, 1);
         check($sformatf("cont%0d_id", k), out_id, exp_g[k]);
         check($sformatf("cont%0d_y", k), y, exp_g[k] ? 4'b1110 : 4'b0011);
         check($sformatf("cont%0d_ack_gone", k), {ack0, ack1}, 0);
         @(negedge clk);
         check($sformatf("cont%0d_valid_drop", k), out_valid, 0);
      end
      @(negedge clk);

      for (int i = 0; i < 6; i++) begin
         run_txn($sformatf("tbl%0d", i), tbl[i].r0, tbl[i].s0, tbl[i].r1, tbl[i].s1,
                 tbl[i].id, tbl[i].ey, tbl[i].enegz);
      end

      // Backpressure: result held for 5 stalled cycles.
      out_ready = 1'b0; req1 = 1'b1; sm1 = 4'b0110;
      wait_ack("bp", n);
      check("bp_ack1", ack1, 1);
      req1 = 1'b0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         check($sformatf("bp%0d_valid", c), out_valid, 1);
         check($sformatf("bp%0d_y", c), y, 4'b0110);
         check($sformatf("bp%0d_noack", c), {ack0, ack1}, 0);
      end
      check("bp_id", out_id, 1);
      out_ready = 1'b1;
      @(negedge clk);
      check("bp_accept", out_valid, 0);

      // Reset while holding a result.
      out_ready = 1'b0; req0 = 1'b1; sm0 = 4'b1101;
      wait_ack("mr", n);
      req0 = 1'b0;
      @(negedge clk);
      check("mr_valid_before", out_valid, 1);
      check("mr_y_before", y, 4'b1011);
      rst_n = 1'b0;
      #1;
      check("mr_valid", out_valid, 0);
      check("mr_y", y, 0);
      check("mr_ack", {ack0, ack1}, 0);
      @(negedge clk);
      rst_n = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      check("mr_noack", {ack0, ack1}, 0);
      check("mr_valid_after", out_valid, 0);
      run_txn("mr_idle", 1'b0, 4'b0000, 1'b1, 4'b0001, 1'b1, 4'b0001, 1'b0);

      // Every 4-bit code on each port.
      for (int p = 0; p < 2; p++) begin
         for (int v = 0; v < 16; v++) begin
            logic [3:0] s;
            s = v[3:0];
            model(s, ey, en);
            if (p == 0)
               run_txn($sformatf("ex0_%0h", v), 1'b1, s, 1'b0, 4'b0000, 1'b0, ey, en);
            else
               run_txn($sformatf("ex1_%0h", v), 1'b0, 4'b0000, 1'b1, s, 1'b1, ey, en);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
